muldiv_issue_ctrl: RTL
======================

Name: muldiv_issue_ctrl

Overview:
- Requester side of the M-extension functional-unit handshake; sits in the EX stage between the pipeline and the multiplier/divider units.
- Accepts M-type ops from EX and resolves RISC-V divide special cases locally.
- Serves a div/rem companion result from a one-entry quotient/remainder cache.
- Otherwise issues to the multiplier or the divider, stalls the pipeline until the unit responds, and presents the 32-bit result.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m_valid  in  1  EX holds a valid M-type op
- funct3  in  3  op select: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- a  in  32  rs1 value
- b  in  32  rs2 value
- flush  in  1  kill the current EX op
- ex_hold  in  1  downstream not accepting; hold the completed result
- stall  out  1  freeze IF/ID/EX
- done  out  1  result valid this cycle
- result  out  32  op result
- mul_enable  out  1  multiplier start, level-held until mul_resp
- mul_a, mul_b  out  32  held operands
- mul_funct3  out  3  held op
- mul_resp  in  1  one-cycle completion pulse
- mul_f  in  32  multiplier result, valid with mul_resp
- div_enable  out  1  divider start, single-cycle pulse
- div_a, div_b  out  32  held operands
- div_funct3  out  3  op select seen by divider
- div_resp  in  1  one-cycle completion pulse
- div_f  in  32  divider result, combinational on div_funct3 after resp

Behaviour:
- States: IDLE, MUL_WAIT, DIV_WAIT, DIV_PAIR, DONE, DRAIN.
- Reset (async): state IDLE; all outputs 0; operand/result registers 0; cache invalid.
- stall = m_valid & (state != DONE). In DONE, stall = 0.
- IDLE, m_valid & !flush, classified by priority:
  - mul group: latch a/b/funct3; mul_enable=1; go to MUL_WAIT.
  - b==0: div/divu result 0xFFFFFFFF; rem/remu result a; go to DONE.
  - signed overflow (div/rem, a=0x80000000, b=0xFFFFFFFF): div 0x80000000, rem 0; go to DONE.
  - cache hit (valid & a,b match & signedness match, signed = ~funct3[0]): result quot if funct3[1]==0, else rem; go to DONE.
  - otherwise: latch operands; div_funct3=funct3; div_enable pulses the cycle after latching; go to DIV_WAIT.
- MUL_WAIT: hold mul_enable/operands. On mul_resp, capture mul_f and go to DONE.
- DIV_WAIT: div_enable=0; operands and div_funct3 held stable. On div_resp, capture div_f as primary and go to DIV_PAIR.
- DIV_PAIR, one cycle:
  - drive div_funct3 = primary ^ 3'b010 (companion rem/div) and capture div_f as companion.
  - Write cache {a, b, signedness, quot, rem}.
  - result = primary; go to DONE.
- DONE: done=1, result stable. ex_hold=1: remain in DONE. Otherwise go to IDLE next cycle.
- Flush in MUL_WAIT or DIV_WAIT: go to DRAIN. DRAIN waits for the pending resp, discards it, leaves the cache unwritten, then goes to IDLE.
  - No new issue until DRAIN exits.
  - stall follows m_valid during DRAIN.
- Flush in IDLE/DONE: go to IDLE, done=0.
- flush in DIV_PAIR: cache write completes, done suppressed.
- Simultaneous flush and resp in a WAIT state: resp is discarded, go to IDLE directly.
- Latencies:
  - special case or cache hit: 1 cycle to done.
  - divider: div latency + 2.
  - multiplier: mul latency + 1.
- No enable to either unit while the other is busy; only one op outstanding.

Test Plan:
- divu a=100 b=7 from IDLE -> one div_enable pulse, stall held until resp; result 14, done one cycle; cache holds q=14 r=2.
- remu a=100 b=7 immediately after -> no div_enable; done next cycle with result 2.
- div 0x80000000/0xFFFFFFFF -> result 0x80000000; rem a=0xFFFFFFF9 b=0 -> result 0xFFFFFFF9; divider never enabled.
- mul a=0xFFFFFFFD b=5 -> mul_enable held until mul_resp; result 0xFFFFFFF1; ex_hold=1 for 3 cycles keeps done/result stable.
- flush during DIV_WAIT, then divu 9/2 presented -> no div_enable until the old div_resp arrives; discarded result not cached; new op result 4.
- rst asserted mid DIV_WAIT -> outputs 0 combinationally; cache invalid (repeat of the prior cached op issues div_enable).

Source files
------------

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: EX-stage requester for the M-extension multiplier and divider.
// Resolves RISC-V divide special cases locally. A one-entry cache returns the
// div/rem companion result. All other ops go to the multiplier or the divider.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   m_valid, funct3     valid M-type op in EX and its op select
//   a, b                rs1 / rs2 operand values
//   flush               kill the op currently in EX
//   ex_hold             downstream stalled; hold the completed result
//   stall               freeze IF/ID/EX while an op is in progress
//   done, result        result valid strobe and 32-bit result
//   mul_enable          multiplier request, held high until mul_resp
//   mul_a, mul_b        operands for the multiplier
//   mul_funct3          op select for the multiplier
//   mul_resp, mul_f     multiplier completion pulse and result
//   div_enable          divider start, one-cycle pulse
//   div_a, div_b        operands for the divider
//   div_funct3          op select seen by the divider
//   div_resp, div_f     divider completion pulse and result
module muldiv_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            mul_enable,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    output logic [2:0]      mul_funct3,
    input  logic            mul_resp,
    input  logic [XLEN-1:0] mul_f,
    output logic            div_enable,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    output logic [2:0]      div_funct3,
    input  logic            div_resp,
    input  logic [XLEN-1:0] div_f
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL_WAIT = 3'd1;
    localparam logic [2:0] S_DIV_WAIT = 3'd2;
    localparam logic [2:0] S_DIV_PAIR = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [2:0]      op_f3_q, op_f3_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            mul_en_q, mul_en_d;
    logic            div_en_q, div_en_d;

    logic            cache_valid_q, cache_valid_d;
    logic [XLEN-1:0] cache_a_q, cache_a_d;
    logic [XLEN-1:0] cache_b_q, cache_b_d;
    logic            cache_signed_q, cache_signed_d;
    logic [XLEN-1:0] cache_quot_q, cache_quot_d;
    logic [XLEN-1:0] cache_rem_q, cache_rem_d;

    logic is_mul;
    logic is_signed;
    logic is_rem;
    logic b_zero;
    logic ovf;
    logic hit;
    logic drain_resp;

    // funct3[2]=0 selects the multiplier group; for div ops funct3[0]=1
    // means unsigned and funct3[1]=1 means remainder.
    assign is_mul    = ~funct3[2];
    assign is_signed = ~funct3[0];
    assign is_rem    = funct3[1];
    assign b_zero    = (b == '0);
    assign ovf       = is_signed && (a == INT_MIN) && (b == ALL_ONE);
    assign hit       = cache_valid_q && (a == cache_a_q) && (b == cache_b_q)
                    && (cache_signed_q == is_signed);

    // While draining, the op register still says which unit owes a response.
    assign drain_resp = op_f3_q[2] ? div_resp : mul_resp;

    always_comb begin
        state_d        = state_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_f3_d        = op_f3_q;
        result_d       = result_q;
        mul_en_d       = mul_en_q && !mul_resp;
        div_en_d       = 1'b0;
        cache_valid_d  = cache_valid_q;
        cache_a_d      = cache_a_q;
        cache_b_d      = cache_b_q;
        cache_signed_d = cache_signed_q;
        cache_quot_d   = cache_quot_q;
        cache_rem_d    = cache_rem_q;

        case (state_q)
            S_IDLE: begin
                if (m_valid && !flush) begin
                    if (is_mul) begin
                        op_a_d   = a;
                        op_b_d   = b;
                        op_f3_d  = funct3;
                        mul_en_d = 1'b1;
                        state_d  = S_MUL_WAIT;
                    end else if (b_zero) begin
                        result_d = is_rem ? a : ALL_ONE;
                        state_d  = S_DONE;
                    end else if (ovf) begin
                        result_d = is_rem ? '0 : INT_MIN;
                        state_d  = S_DONE;
                    end else if (hit) begin
                        result_d = is_rem ? cache_rem_q : cache_quot_q;
                        state_d  = S_DONE;
                    end else begin
                        op_a_d   = a;
                        op_b_d   = b;
                        op_f3_d  = funct3;
                        div_en_d = 1'b1;
                        state_d  = S_DIV_WAIT;
                    end
                end
            end

            S_MUL_WAIT: begin
                if (mul_resp) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        result_d = mul_f;
                        state_d  = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end

            S_DIV_WAIT: begin
                if (div_resp) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        result_d = div_f;
                        state_d  = S_DIV_PAIR;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end

            // result_q holds the primary result; div_f now shows the
            // companion because div_funct3 has its rem/div bit flipped.
            S_DIV_PAIR: begin
                cache_valid_d  = 1'b1;
                cache_a_d      = op_a_q;
                cache_b_d      = op_b_q;
                cache_signed_d = ~op_f3_q[0];
                cache_quot_d   = op_f3_q[1] ? div_f : result_q;
                cache_rem_d    = op_f3_q[1] ? result_q : div_f;
                state_d        = flush ? S_IDLE : S_DONE;
            end

            S_DONE: begin
                if (flush || !ex_hold) begin
                    state_d = S_IDLE;
                end
            end

            S_DRAIN: begin
                if (drain_resp) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_f3_q        <= '0;
            result_q       <= '0;
            mul_en_q       <= 1'b0;
            div_en_q       <= 1'b0;
            cache_valid_q  <= 1'b0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_signed_q <= 1'b0;
            cache_quot_q   <= '0;
            cache_rem_q    <= '0;
        end else begin
            state_q        <= state_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_f3_q        <= op_f3_d;
            result_q       <= result_d;
            mul_en_q       <= mul_en_d;
            div_en_q       <= div_en_d;
            cache_valid_q  <= cache_valid_d;
            cache_a_q      <= cache_a_d;
            cache_b_q      <= cache_b_d;
            cache_signed_q <= cache_signed_d;
            cache_quot_q   <= cache_quot_d;
            cache_rem_q    <= cache_rem_d;
        end
    end

    // Reset forces stall low even while EX still presents a valid op.
    assign stall      = m_valid && (state_q != S_DONE) && !rst;
    assign done       = (state_q == S_DONE) && !flush;
    assign result     = result_q;
    assign mul_enable = mul_en_q;
    assign mul_a      = op_a_q;
    assign mul_b      = op_b_q;
    assign mul_funct3 = op_f3_q;
    assign div_enable = div_en_q;
    assign div_a      = op_a_q;
    assign div_b      = op_b_q;
    assign div_funct3 = (state_q == S_DIV_PAIR) ? (op_f3_q ^ 3'b010) : op_f3_q;

endmodule
